cpu_mem_responder: RTL and testbench
====================================

Name: cpu_mem_responder

Overview:
- Memory-side responder for the CPU's byte-wide bus: the CPU initiates; this block answers instruction fetches, data loads and stores.
- Owns the byte-addressed program/data memory.
- Sequences boot: accepts a program image over a valid/ready load port, holds the CPU in reset until the load completes, then releases it.
- During run, watches stores to the flag address and streams flagged output bytes through a small FIFO to the host side.

Parameters:
- MEM_DEPTH, 1024, memory size in bytes; valid addresses are 0..MEM_DEPTH-1.
- FLAG_ADDR, 32'h000000FF, store address that toggles the capture flag.
- FIFO_DEPTH, 8, output FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- load_valid  in  1  program byte offered.
- load_ready  out  1  responder accepts a program byte this cycle.
- load_addr  in  32  byte address of the program byte.
- load_byte  in  8  program byte.
- load_last  in  1  marks the final program byte.
- cpu_reset  out  1  active-high synchronous reset to the CPU.
- address  in  32  CPU bus address.
- read_data  out  8  byte returned to the CPU, combinational.
- write_data_mem  in  8  CPU store byte.
- writeBack  in  1  CPU store strobe, one cycle per store.
- out_valid  out  1  captured byte available.
- out_ready  in  1  consumer takes the byte.
- out_byte  out  8  captured byte.
- fault  out  1  sticky out-of-range access flag.
- overflow  out  1  sticky flag for a capture dropped while the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous) sets these values: state=LOAD, cpu_reset=1, load_ready=1, out_valid=0, FIFO empty, capture flag=0, fault=0, overflow=0. Memory contents are not reset.
- State LOAD:
  - Handshake completes when load_valid&&load_ready; the responder writes mem[load_addr]<=load_byte on that edge.
  - A load_addr >= MEM_DEPTH drops the byte and sets fault.
  - A handshake with load_last=1 moves the state to RELEASE.
  - The CPU bus is ignored in this state and read_data=8'h00.
- State RELEASE:
  - Lasts exactly one cycle, with cpu_reset=1 and load_ready=0, so the CPU sees its synchronous reset on at least one edge after the last byte.
  - Then moves to RUN.
- State RUN:
  - cpu_reset=0 and load_ready=0; load_valid is ignored.
  - The only exit is reset.
- Read path in RUN:
  - read_data = mem[address] in the same cycle, with no latency; the CPU samples it combinationally.
  - address >= MEM_DEPTH returns 8'h00 and sets fault.
- Store path in RUN: on writeBack=1, mem[address]<=write_data_mem. An out-of-range store is dropped and sets fault.
- Capture flag:
  - On writeBack with address==FLAG_ADDR, flag<=~flag. The memory is also written.
- Capture push:
  - Condition: writeBack=1, address!=FLAG_ADDR, and the flag value before this edge is 1.
  - Action: push write_data_mem into the FIFO.
  - A store to FLAG_ADDR is never captured.
- FIFO:
  - out_valid = !empty, and out_byte = head.
  - Pop occurs on out_valid&&out_ready.
  - out_byte is stable while out_valid=1 and out_ready=0.
- FIFO full:
  - A push while full and not popping is dropped and sets overflow.
  - Simultaneous push and pop while full: both happen and the count is unchanged.
  - Simultaneous push and pop while empty: the push is stored and out_valid rises next cycle (no bypass).
- Pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.
- Reset asserted mid-load or mid-run aborts immediately. The memory keeps partial contents, and the next boot must reload.

Decomposition:
- Shared package holds:
  - The state enum LOAD/RELEASE/RUN.
  - The FLAG_ADDR default.
  - The CPU bus byte width constant (8).
- One sub-module: byte_fifo, parameterised on depth.
  - Ports: push, data in, pop, data out, empty, full.
  - Same async active-low reset as this block.
- Memory array, address range checks, flag and FSM live in the top block.

Test Plan:
- Boot sequence:
  - Stimulus: load 4 bytes {0x11,0x22,0x33,0x44} to addresses 0..3, with load_last on the 4th.
  - Response: cpu_reset stays 1 through the handshake cycle plus one RELEASE cycle, then 0; address=2 gives read_data=0x33 combinationally.
- Capture:
  - Stimulus in RUN: store 0x01 to 0xFF (flag->1), store 0xAB to 0x100, store 0x02 to 0xFF (flag->0), store 0xCD to 0x101.
  - Response: exactly one FIFO entry, 0xAB; mem[0x101]=0xCD.
- Backpressure:
  - Stimulus: flag=1, 9 stores with out_ready=0 and FIFO_DEPTH=8.
  - Response: 8 entries held and overflow=1. Releasing out_ready drains in store order, with out_byte stable while stalled.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full, then a push and pop in the same cycle.
  - Response: overflow stays 0, count stays 8, and the new byte appears last.
- Out of range:
  - Stimulus: load_addr=MEM_DEPTH during LOAD, then a RUN read at MEM_DEPTH+5.
  - Response: fault=1, read_data=0x00, memory unchanged.
- Reset mid-run:
  - Stimulus: assert reset=0 asynchronously with 3 bytes queued.
  - Response: out_valid=0, cpu_reset=1 and load_ready=1 immediately, without waiting for a clock; flag=0 after release.

Source files
------------

// File: rtl/cpu_mem_responder_pkg.sv
// Shared types and constants for the CPU memory responder and its output FIFO.
package cpu_mem_responder_pkg;

   localparam int          BUS_W             = 8;
   localparam logic [31:0] FLAG_ADDR_DEFAULT = 32'h0000_00FF;

   typedef enum logic [1:0] {
      ST_LOAD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_e;

endpackage

// File: rtl/cpu_mem_responder_byte_fifo.sv
// Byte-wide FIFO with combinational head; push while full is accepted only alongside a pop.
module byte_fifo
   import cpu_mem_responder_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [BUS_W-1:0] din,
   input  logic             pop,
   output logic [BUS_W-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int PW = $clog2(DEPTH);

   logic [BUS_W-1:0] fifo_mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      empty    = (count_q == '0);
      full     = (count_q == (PW+1)'(DEPTH));
      do_pop   = pop && !empty;
      // An empty FIFO never pops, so a simultaneous push is simply stored.
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   assign dout = fifo_mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) fifo_mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder: boots the CPU from a loaded image, serves its byte bus,
// and streams bytes stored while the capture flag is set to the host.
module cpu_mem_responder
   import cpu_mem_responder_pkg::*;
#(
   parameter int          MEM_DEPTH  = 1024,
   parameter logic [31:0] FLAG_ADDR  = FLAG_ADDR_DEFAULT,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [31:0]      load_addr,
   input  logic [BUS_W-1:0] load_byte,
   input  logic             load_last,
   output logic             cpu_reset,
   input  logic [31:0]      address,
   output logic [BUS_W-1:0] read_data,
   input  logic [BUS_W-1:0] write_data_mem,
   input  logic             writeBack,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BUS_W-1:0] out_byte,
   output logic             fault,
   output logic             overflow
);

   localparam int          AW          = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [31:0] MEM_DEPTH_W = 32'(MEM_DEPTH);

   logic [BUS_W-1:0] mem_q [MEM_DEPTH];

   state_e state_q, state_d;
   logic   flag_q, flag_d;
   logic   fault_q, fault_d;
   logic   overflow_q, overflow_d;

   logic             run, load_fire, load_in_range, addr_in_range;
   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [BUS_W-1:0] mem_wdata;
   logic             cap_push, fifo_pop, fifo_empty, fifo_full;

   always_comb begin
      run           = (state_q == ST_RUN);
      load_fire     = load_valid && (state_q == ST_LOAD);
      load_in_range = (load_addr < MEM_DEPTH_W);
      addr_in_range = (address < MEM_DEPTH_W);

      state_d    = state_q;
      flag_d     = flag_q;
      fault_d    = fault_q;
      overflow_d = overflow_q;
      mem_we     = 1'b0;
      mem_waddr  = address[AW-1:0];
      mem_wdata  = write_data_mem;
      read_data  = '0;

      case (state_q)
         ST_LOAD: begin
            if (load_fire) begin
               if (load_in_range) begin
                  mem_we    = 1'b1;
                  mem_waddr = load_addr[AW-1:0];
                  mem_wdata = load_byte;
               end else begin
                  fault_d = 1'b1;
               end
               if (load_last) state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: state_d = ST_RUN;
         ST_RUN: begin
            // The CPU address is sampled every cycle, so an out-of-range address faults even without a store.
            if (addr_in_range) read_data = mem_q[address[AW-1:0]];
            else               fault_d   = 1'b1;
            if (writeBack) begin
               if (addr_in_range)          mem_we = 1'b1;
               if (address == FLAG_ADDR)   flag_d = ~flag_q;
            end
         end
         default: state_d = ST_LOAD;
      endcase

      cap_push = run && writeBack && (address != FLAG_ADDR) && flag_q;
      fifo_pop = out_valid && out_ready;
      if (cap_push && fifo_full && !fifo_pop) overflow_d = 1'b1;
   end

   assign load_ready = (state_q == ST_LOAD);
   assign cpu_reset  = (state_q != ST_RUN);
   assign out_valid  = !fifo_empty;
   assign fault      = fault_q;
   assign overflow   = overflow_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_LOAD;
         flag_q     <= 1'b0;
         fault_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         flag_q     <= flag_d;
         fault_q    <= fault_d;
         overflow_q <= overflow_d;
      end
   end

   // Memory contents deliberately survive reset so a partial image stays visible.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (cap_push),
      .din   (write_data_mem),
      .pop   (fifo_pop),
      .dout  (out_byte),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: boot, capture, backpressure, full push/pop, reset and range faults.
module tb_cpu_mem_responder;

   localparam int MEM_DEPTH = 1024;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_valid, load_ready, load_last;
   logic [31:0] load_addr, address;
   logic [7:0]  load_byte, read_data, write_data_mem, out_byte;
   logic        cpu_reset, writeBack, out_valid, out_ready, fault, overflow;

   int tests_run    = 0;
   int tests_failed = 0;

   cpu_mem_responder #(.MEM_DEPTH(MEM_DEPTH), .FLAG_ADDR(32'h0000_00FF), .FIFO_DEPTH(8)) dut (
      .clk(clk), .reset(reset),
      .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
      .load_byte(load_byte), .load_last(load_last), .cpu_reset(cpu_reset),
      .address(address), .read_data(read_data), .write_data_mem(write_data_mem),
      .writeBack(writeBack), .out_valid(out_valid), .out_ready(out_ready),
      .out_byte(out_byte), .fault(fault), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // One load handshake, entered and left on a falling edge.
   task automatic do_load(input logic [31:0] a, input logic [7:0] b, input logic last);
      $display("[TB] load addr=%h byte=%h last=%b", a, b, last);
      load_valid = 1'b1; load_addr = a; load_byte = b; load_last = last;
      @(negedge clk);
      load_valid = 1'b0; load_last = 1'b0;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [7:0] d);
      $display("[TB] store addr=%h data=%h", a, d);
      writeBack = 1'b1; address = a; write_data_mem = d;
      @(negedge clk);
      writeBack = 1'b0; address = 32'h0;
   endtask

   // Pulse reset and boot a one-byte image (0x11 at address 0), ending in RUN.
   task automatic reboot();
      $display("[TB] reboot");
      writeBack = 1'b0; out_ready = 1'b0; address = 32'h0; load_valid = 1'b0;
      reset = 1'b0;
      #1 reset = 1'b1;
      @(negedge clk);
      do_load(32'h0, 8'h11, 1'b1);
      @(negedge clk);
   endtask

   task automatic test_reset();
      #2;
      tests_run++;
      if (cpu_reset !== 1'b1 || load_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_ctrl: cpu_reset=%b load_ready=%b expected 1 1", cpu_reset, load_ready);
      end
      tests_run++;
      if (out_valid !== 1'b0 || fault !== 1'b0 || overflow !== 1'b0 || read_data !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_flags: out_valid=%b fault=%b overflow=%b read_data=%h expected 0 0 0 00",
                  out_valid, fault, overflow, read_data);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_boot();
      logic [7:0] img [4];
      img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
      for (int i = 0; i < 4; i++) begin
         $display("[TB] boot load addr=%0d byte=%h", i, img[i]);
         load_valid = 1'b1; load_addr = 32'(i); load_byte = img[i]; load_last = (i == 3);
         #1;
         tests_run++;
         if (load_ready !== 1'b1 || cpu_reset !== 1'b1) begin
            tests_failed++;
            $display("FAIL boot_load_%0d: load_ready=%b cpu_reset=%b expected 1 1", i, load_ready, cpu_reset);
         end
         @(negedge clk);
      end
      load_valid = 1'b0; load_last = 1'b0;
      tests_run++;
      if (cpu_reset !== 1'b1 || load_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL boot_release: cpu_reset=%b load_ready=%b expected 1 0", cpu_reset, load_ready);
      end
      @(negedge clk);
      tests_run++;
      if (cpu_reset !== 1'b0 || load_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL boot_run: cpu_reset=%b load_ready=%b expected 0 0", cpu_reset, load_ready);
      end
      address = 32'd2;
      #1;
      tests_run++;
      if (read_data !== 8'h33) begin
         tests_failed++;
         $display("FAIL boot_read2: read_data=%h expected 33", read_data);
      end
      address = 32'd3;
      #1;
      tests_run++;
      if (read_data !== 8'h44 || fault !== 1'b0) begin
         tests_failed++;
         $display("FAIL boot_read3: read_data=%h fault=%b expected 44 0", read_data, fault);
      end
      address = 32'd0;
      @(negedge clk);
   endtask

   task automatic test_capture();
      out_ready = 1'b0;
      do_store(32'h0FF, 8'h01);
      do_store(32'h100, 8'hAB);
      do_store(32'h0FF, 8'h02);
      do_store(32'h101, 8'hCD);
      tests_run++;
      if (out_valid !== 1'b1 || out_byte !== 8'hAB) begin
         tests_failed++;
         $display("FAIL capture_head: out_valid=%b out_byte=%h expected 1 ab", out_valid, out_byte);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL capture_single: out_valid=%b expected 0 after one pop", out_valid);
      end
      address = 32'h101;
      #1;
      tests_run++;
      if (read_data !== 8'hCD) begin
         tests_failed++;
         $display("FAIL capture_mem101: read_data=%h expected cd", read_data);
      end
      address = 32'h0FF;
      #1;
      tests_run++;
      if (read_data !== 8'h02) begin
         tests_failed++;
         $display("FAIL capture_memff: read_data=%h expected 02", read_data);
      end
      address = 32'h0;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      do_store(32'h0FF, 8'h01);
      for (int i = 0; i < 9; i++) begin
         if (i == 8) begin
            tests_run++;
            if (overflow !== 1'b0) begin
               tests_failed++;
               $display("FAIL bp_no_overflow_yet: overflow=%b expected 0", overflow);
            end
         end
         do_store(32'h200 + 32'(i), 8'h50 + 8'(i));
      end
      tests_run++;
      if (overflow !== 1'b1 || out_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_overflow: overflow=%b out_valid=%b expected 1 1", overflow, out_valid);
      end
      for (int s = 0; s < 2; s++) begin
         tests_run++;
         if (out_byte !== 8'h50) begin
            tests_failed++;
            $display("FAIL bp_stall_%0d: out_byte=%h expected 50", s, out_byte);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         tests_run++;
         if (out_valid !== 1'b1 || out_byte !== 8'h50 + 8'(i)) begin
            tests_failed++;
            $display("FAIL bp_drain_%0d: out_valid=%b out_byte=%h expected 1 %h", i, out_valid, out_byte, 8'h50 + 8'(i));
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_drained: out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_full_push_pop();
      reboot();
      do_store(32'h0FF, 8'h01);
      for (int i = 0; i < 8; i++) do_store(32'h300 + 32'(i), 8'h60 + 8'(i));
      $display("[TB] push 68 with pop while full");
      writeBack = 1'b1; address = 32'h308; write_data_mem = 8'h68; out_ready = 1'b1;
      #1;
      tests_run++;
      if (out_byte !== 8'h60 || overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_pp_head: out_byte=%h overflow=%b expected 60 0", out_byte, overflow);
      end
      @(negedge clk);
      writeBack = 1'b0; address = 32'h0; out_ready = 1'b0;
      tests_run++;
      if (overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_pp_overflow: overflow=%b expected 0", overflow);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         tests_run++;
         if (out_valid !== 1'b1 || out_byte !== 8'h61 + 8'(i)) begin
            tests_failed++;
            $display("FAIL full_pp_drain_%0d: out_valid=%b out_byte=%h expected 1 %h", i, out_valid, out_byte, 8'h61 + 8'(i));
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_pp_count: out_valid=%b expected 0 after 8 pops", out_valid);
      end
   endtask

   task automatic test_reset_mid_run();
      for (int i = 0; i < 3; i++) do_store(32'h310 + 32'(i), 8'h70 + 8'(i));
      tests_run++;
      if (out_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_reset_queued: out_valid=%b expected 1", out_valid);
      end
      #2 reset = 1'b0;
      $display("[TB] async reset asserted mid-run");
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || cpu_reset !== 1'b1 || load_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_reset_async: out_valid=%b cpu_reset=%b load_ready=%b expected 0 1 1",
                  out_valid, cpu_reset, load_ready);
      end
      reset = 1'b1;
      address = 32'd2;
      #1;
      tests_run++;
      if (read_data !== 8'h00) begin
         tests_failed++;
         $display("FAIL mid_reset_load_read: read_data=%h expected 00", read_data);
      end
      address = 32'h0;
      @(negedge clk);
      do_load(32'h0, 8'h11, 1'b1);
      @(negedge clk);
      do_store(32'h3F0, 8'h77);
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset_flag: out_valid=%b expected 0 (flag cleared)", out_valid);
      end
      address = 32'h3F0;
      #1;
      tests_run++;
      if (read_data !== 8'h77) begin
         tests_failed++;
         $display("FAIL mid_reset_store: read_data=%h expected 77", read_data);
      end
      address = 32'h0;
      @(negedge clk);
   endtask

   task automatic test_out_of_range();
      reset = 1'b0;
      #1 reset = 1'b1;
      @(negedge clk);
      do_load(32'(MEM_DEPTH), 8'h99, 1'b0);
      tests_run++;
      if (fault !== 1'b1) begin
         tests_failed++;
         $display("FAIL oor_load_fault: fault=%b expected 1", fault);
      end
      do_load(32'h3, 8'h44, 1'b1);
      @(negedge clk);
      address = 32'h0;
      #1;
      tests_run++;
      if (read_data !== 8'h11) begin
         tests_failed++;
         $display("FAIL oor_mem_unchanged: read_data=%h expected 11", read_data);
      end
      reboot();
      tests_run++;
      if (fault !== 1'b0) begin
         tests_failed++;
         $display("FAIL oor_fault_cleared: fault=%b expected 0", fault);
      end
      address = 32'(MEM_DEPTH + 5);
      $display("[TB] read addr=%h", address);
      #1;
      tests_run++;
      if (read_data !== 8'h00) begin
         tests_failed++;
         $display("FAIL oor_read_data: read_data=%h expected 00", read_data);
      end
      @(negedge clk);
      address = 32'h0;
      tests_run++;
      if (fault !== 1'b1) begin
         tests_failed++;
         $display("FAIL oor_read_fault: fault=%b expected 1", fault);
      end
   endtask

   initial begin
      reset = 1'b0;
      load_valid = 1'b0; load_addr = 32'h0; load_byte = 8'h00; load_last = 1'b0;
      address = 32'h0; write_data_mem = 8'h00; writeBack = 1'b0; out_ready = 1'b0;
      test_reset();
      test_boot();
      test_capture();
      test_backpressure();
      test_full_push_pop();
      test_reset_mid_run();
      test_out_of_range();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
